// File: rtl/one_port_mem_req_adapter.sv
// Valid/ready request front-end for single-port vendor memories. Read data returns 2 edges after acceptance.
// Read acceptance reserves response FIFO space, so a stalled consumer throttles reads only; writes always proceed.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = store[rd_ptr];
endmodule

module one_port_mem_req_adapter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] A,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             rd_pend;
  logic             pop;
  logic             fire;
  logic             read_room;

  assign pop = rsp_valid & rsp_ready;

  // Occupancy counts the read whose data lands next edge, minus the entry leaving this edge.
  always_comb begin
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend} - {{CNT_W{1'b0}}, pop};
    read_room = occupancy < (CNT_W + 1)'(RSP_DEPTH);
  end

  assign req_ready = ~RST & (req_we | read_room);
  assign fire      = req_valid & req_ready;

  assign CEN = ~fire;
  assign WEN = fire ? ~req_we : 1'b1;
  assign A   = req_addr;
  assign D   = req_wdata;
  assign OEN = 1'b0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= fire & ~req_we;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rd_pend),
    .push_data (Q),
    .pop       (pop),
    .pop_data  (rsp_data),
    .count     (count)
  );

  assign rsp_valid = (count != '0);
endmodule

// File: tb/tb_one_port_mem_req_adapter.sv
// Directed and random checks of the request adapter against behavioural vendor memories.
// dut uses RSP_DEPTH=2; dut3 uses RSP_DEPTH=3 for the randomized scoreboard run.
module tb_one_port_mem_req_adapter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [7:0] req_addr, req_wdata, rsp_data, A, D, Q;
  logic       CEN, WEN, OEN;

  logic       r_req_valid, r_req_ready, r_req_we, r_rsp_valid, r_rsp_ready;
  logic [7:0] r_req_addr, r_req_wdata, r_rsp_data, r_A, r_D, r_Q;
  logic       r_CEN, r_WEN, r_OEN;

  one_port_mem_req_adapter #(.ADDR_W(8), .DATA_W(8), .RSP_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .A(A), .CEN(CEN), .WEN(WEN), .OEN(OEN), .D(D), .Q(Q)
  );

  one_port_mem_req_adapter #(.ADDR_W(8), .DATA_W(8), .RSP_DEPTH(3)) dut3 (
    .CLK(CLK), .RST(RST), .req_valid(r_req_valid), .req_ready(r_req_ready), .req_we(r_req_we),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata), .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready),
    .rsp_data(r_rsp_data), .A(r_A), .CEN(r_CEN), .WEN(r_WEN), .OEN(r_OEN), .D(r_D), .Q(r_Q)
  );

  // Vendor memory models: write on the CEN edge, Q registered one edge after a read.
  logic [7:0] mem  [256];
  logic [7:0] mem3 [256];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= mem[A];
    end
  end
  always @(posedge CLK) begin
    if (!r_CEN) begin
      if (!r_WEN) mem3[r_A] <= r_D;
      else        r_Q <= mem3[r_A];
    end
  end

  logic [7:0] log_dat [$];
  int         log_cyc [$];
  always @(negedge CLK) begin
    if (rsp_valid && rsp_ready) begin
      log_dat.push_back(rsp_data);
      log_cyc.push_back(cyc);
    end
  end

  logic [7:0] sb [256];
  logic [7:0] exp_q [$];

  task automatic test_reset();
    RST = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_wdata = 8'h00; rsp_ready = 1'b1;
    r_req_valid = 1'b1; r_req_we = 1'b1; r_req_addr = 8'h00; r_req_wdata = 8'h00; r_rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (CEN !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b want 1", CEN); end
    checks++; if (WEN !== 1'b1) begin errors++; $display("FAIL reset_wen: got %b want 1", WEN); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (OEN !== 1'b0 || r_OEN !== 1'b0) begin errors++; $display("FAIL reset_oen: got %b/%b want 0/0", OEN, r_OEN); end
    checks++; if (r_CEN !== 1'b1 || r_req_ready !== 1'b0) begin errors++; $display("FAIL reset_dut3_gate: cen %b ready %b want 1 0", r_CEN, r_req_ready); end
    @(posedge CLK); #1;
    RST = 1'b0; r_req_valid = 1'b0;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b want 1", req_ready); end
    req_valid = 1'b0;
  endtask

  task automatic test_write_read();
    int base;
    base = log_dat.size();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5; rsp_ready = 1'b1;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1 || CEN !== 1'b0 || WEN !== 1'b0) begin
      errors++; $display("FAIL write_pins: ready %b cen %b wen %b want 1 0 0", req_ready, CEN, WEN); end
    checks++; if (A !== 8'h10 || D !== 8'hA5) begin errors++; $display("FAIL write_addr_data: A %h D %h want 10 a5", A, D); end
    @(posedge CLK); #1;
    req_we = 1'b0;
    @(negedge CLK);
    checks++; if (CEN !== 1'b0 || WEN !== 1'b1) begin errors++; $display("FAIL read_pins: cen %b wen %b want 0 1", CEN, WEN); end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    checks++; if (CEN !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read_edge1: cen %b rsp_valid %b want 1 0", CEN, rsp_valid); end
    @(negedge CLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
      errors++; $display("FAIL read_edge2: rsp_valid %b data %h want 1 a5", rsp_valid, rsp_data); end
    @(negedge CLK);
    checks++; if (rsp_valid !== 1'b0 || log_dat.size() != base + 1) begin
      errors++; $display("FAIL read_single_rsp: rsp_valid %b count %0d want 0 1", rsp_valid, log_dat.size() - base); end
  endtask

  task automatic test_back_to_back();
    int base, drops;
    drops = 0;
    req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr = 8'(i); req_wdata = 8'(i) ^ 8'hFF;
      @(negedge CLK); if (!req_ready) drops++;
      @(posedge CLK); #1;
    end
    base = log_dat.size();
    req_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_addr = 8'(i);
      @(negedge CLK); if (!req_ready) drops++;
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge CLK); #1;
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_ready_drops: got %0d want 0", drops); end
    checks++; if (log_dat.size() - base != 16) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 16", log_dat.size() - base); end
    for (int i = 0; i < 16 && base + i < log_dat.size(); i++) begin
      checks++; if (log_dat[base + i] !== 8'(255 - i)) begin
        errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, log_dat[base + i], 8'(255 - i)); end
      checks++; if (log_cyc[base + i] != log_cyc[base] + i) begin
        errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, log_cyc[base + i], log_cyc[base] + i); end
    end
  endtask

  task automatic test_backpressure();
    int base, idx;
    logic take;
    base = log_dat.size(); idx = 0;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
    repeat (6) begin
      @(negedge CLK); take = req_ready;
      @(posedge CLK); #1;
      if (take) begin idx++; req_addr = 8'(idx); end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    @(negedge CLK);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_read_blocked: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF) begin
      errors++; $display("FAIL bp_head_held: valid %b data %h want 1 ff", rsp_valid, rsp_data); end
    req_we = 1'b1; req_addr = 8'h30; req_wdata = 8'h77;
    #1;
    checks++; if (req_ready !== 1'b1 || CEN !== 1'b0) begin
      errors++; $display("FAIL bp_write_accepted: ready %b cen %b want 1 0", req_ready, CEN); end
    @(posedge CLK); #1;
    req_we = 1'b0; req_addr = 8'(idx); rsp_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge CLK); take = req_ready;
      @(posedge CLK); #1;
      if (take) begin idx++; req_addr = 8'(idx); end
      if (idx >= 4) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_all_reads: got %0d want 4", idx); end
    repeat (5) @(posedge CLK); #1;
    checks++; if (log_dat.size() - base != 4) begin errors++; $display("FAIL bp_rsp_count: got %0d want 4", log_dat.size() - base); end
    for (int i = 0; i < 4 && base + i < log_dat.size(); i++) begin
      checks++; if (log_dat[base + i] !== 8'(255 - i)) begin
        errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, log_dat[base + i], 8'(255 - i)); end
    end
  endtask

  task automatic test_rw_order();
    int base;
    logic r1, r2, r3;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h11;
    @(posedge CLK); #1;
    base = log_dat.size();
    req_we = 1'b0;
    @(negedge CLK); r1 = req_ready; @(posedge CLK); #1;
    req_we = 1'b1; req_wdata = 8'h22;
    @(negedge CLK); r2 = req_ready; @(posedge CLK); #1;
    req_we = 1'b0;
    @(negedge CLK); r3 = req_ready; @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge CLK); #1;
    checks++; if ({r1, r2, r3} !== 3'b111) begin errors++; $display("FAIL rw_ready: got %b want 111", {r1, r2, r3}); end
    checks++; if (log_dat.size() - base != 2) begin errors++; $display("FAIL rw_rsp_count: got %0d want 2", log_dat.size() - base); end
    if (log_dat.size() - base >= 2) begin
      checks++; if (log_dat[base] !== 8'h11) begin errors++; $display("FAIL rw_old_data: got %h want 11", log_dat[base]); end
      checks++; if (log_dat[base + 1] !== 8'h22) begin errors++; $display("FAIL rw_new_data: got %h want 22", log_dat[base + 1]); end
    end
  endtask

  task automatic test_reset_midflight();
    int base;
    logic ra, rb, rr;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h5A;
    @(posedge CLK); #1;
    rsp_ready = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    base = log_dat.size();
    @(negedge CLK); ra = req_ready; @(posedge CLK); #1;
    req_addr = 8'h01;
    @(negedge CLK); rb = req_ready; @(posedge CLK); #1;
    req_addr = 8'h02;
    checks++; if ({ra, rb} !== 2'b11 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup: ready %b rsp_valid %b want 11 1", {ra, rb}, rsp_valid); end
    RST = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (CEN !== 1'b1 || req_ready !== 1'b0 || WEN !== 1'b1) begin
      errors++; $display("FAIL mid_gate: cen %b ready %b wen %b want 1 0 1", CEN, req_ready, WEN); end
    @(posedge CLK); #1;
    RST = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(posedge CLK); #1;
    checks++; if (log_dat.size() != base) begin errors++; $display("FAIL mid_stale: got %0d responses want 0", log_dat.size() - base); end
    req_valid = 1'b1; req_addr = 8'h40;
    @(negedge CLK); rr = req_ready; @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge CLK); #1;
    checks++; if (rr !== 1'b1 || log_dat.size() != base + 1) begin
      errors++; $display("FAIL mid_after_read: ready %b count %0d want 1 1", rr, log_dat.size() - base); end
    if (log_dat.size() == base + 1) begin
      checks++; if (log_dat[base] !== 8'h5A) begin errors++; $display("FAIL mid_after_data: got %h want 5a", log_dat[base]); end
    end
  endtask

  task automatic test_random();
    int sent, max_out;
    sent = 0; max_out = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      if (sent < 16) begin
        r_req_valid = 1'b1; r_req_we = 1'b1; r_req_addr = 8'(sent); r_req_wdata = 8'($urandom);
      end else begin
        r_req_valid = ($urandom_range(0, 3) != 0);
        r_req_we    = 1'($urandom_range(0, 1));
        r_req_addr  = 8'($urandom_range(0, 15));
        r_req_wdata = 8'($urandom);
      end
      r_rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge CLK);
      if (r_rsp_valid && r_rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_unexpected_rsp: got %h want none", r_rsp_data); end
        else begin
          if (r_rsp_data !== exp_q[0]) begin errors++; $display("FAIL rand_rsp_data: got %h want %h", r_rsp_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (r_req_valid && r_req_ready) begin
        sent++;
        if (r_req_we) sb[r_req_addr] = r_req_wdata;
        else exp_q.push_back(sb[r_req_addr]);
      end
      if (exp_q.size() > max_out) max_out = exp_q.size();
      @(posedge CLK); #1;
    end
    r_req_valid = 1'b0; r_rsp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge CLK);
      if (r_rsp_valid) begin
        checks++;
        if (r_rsp_data !== exp_q[0]) begin errors++; $display("FAIL rand_drain_data: got %h want %h", r_rsp_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(posedge CLK); #1;
    end
    checks++; if (sent != 10000) begin errors++; $display("FAIL rand_sent: got %0d want 10000", sent); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost_rsp: got %0d outstanding want 0", exp_q.size()); end
    checks++; if (max_out > 3) begin errors++; $display("FAIL rand_occupancy: got %0d want <=3", max_out); end
    checks++; if (max_out < 3) begin errors++; $display("FAIL rand_fill: got max %0d want 3", max_out); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_rw_order();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/one_port_mem_req_adapter.md
Name: one_port_mem_req_adapter

Overview:
Upstream front-end for the generated single-port vendor memories (e.g. someOnePortVendorMem_256_8_16). It converts a valid/ready request stream (read or write) into the vendor pin protocol (active-low CEN/WEN, registered Q one cycle after the read edge). It returns read data on a valid/ready response stream through a small response FIFO, so downstream backpressure never loses data.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
RSP_DEPTH, 2, response FIFO entries; legal values are >= 2

Ports:
CLK  input  1  sole clock; memory shares it
RST  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted on CLK edge when valid&ready
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes rsp_data on edge when valid&ready
rsp_data  output  DATA_W  read data, FIFO head
A  output  ADDR_W  to memory A
CEN  output  1  to memory CEN, active low
WEN  output  1  to memory WEN, active low
OEN  output  1  to memory OEN
D  output  DATA_W  to memory D
Q  input  DATA_W  from memory Q

Behaviour:
- Clock is CLK only. RST is asynchronous and active-high.
- Memory pins are combinational from the request:
  - fire = req_valid & req_ready & ~RST
  - CEN = ~fire
  - WEN = ~req_we when fire, else 1
  - A = req_addr
  - D = req_wdata
  - OEN = 0 constant
- State is held in two places:
  - rd_pend flop: a read fired on the previous edge.
  - Response FIFO: RSP_DEPTH entries with wr_ptr, rd_ptr and count. Pointers wrap modulo RSP_DEPTH; count width is clog2(RSP_DEPTH+1).
- Read path:
  - Read fires at edge k, so rd_pend=1 after edge k.
  - At edge k+1, Q is pushed into the FIFO.
  - rsp_valid rises after edge k+1. Read latency is 2 edges from acceptance.
- Write path:
  - Write fires at edge k and the memory updates at edge k.
  - No response is generated.
  - Writes are never blocked by FIFO state.
- req_ready:
  - Equals 1 when req_we=1.
  - When req_we=0, equals (count + rd_pend - pop < RSP_DEPTH), where pop = rsp_valid & rsp_ready. This is a combinational path from rsp_ready.
  - This guarantees the FIFO never overflows. With RSP_DEPTH>=2 and rsp_ready held 1, reads sustain one per cycle.
- Same-cycle push and pop: count is unchanged and both pointers advance. When count=0, a push is not visible until the next cycle (no bypass).
- rsp_valid = (count != 0). rsp_data = fifo[rd_ptr], held stable while rsp_valid & ~rsp_ready.
- Ordering:
  - Responses are returned in request order.
  - A read followed by a write to the same address returns the old data.
  - A write followed by a read returns the new data.
- Reset, asserted at any time:
  - Immediately: CEN=1, WEN=1, req_ready=0 (all gated by RST).
  - Flops clear: rd_pend=0, count=0, pointers=0, so rsp_valid=0.
  - In-flight reads are dropped and not returned after reset.
  - Memory contents are untouched.
- RST release: the first request can be accepted on the first edge after deassertion.

Test Plan:
- Reset, then write addr 0x10 data 0xA5, then read 0x10 with rsp_ready=1 -> CEN low for 1 cycle each; WEN=0 on the write, WEN=1 on the read; rsp_valid rises 2 edges after read acceptance with rsp_data=0xA5.
- Back-to-back reads of 0x00..0x0F after writing data=addr^0xFF, rsp_ready=1 -> req_ready never drops; 16 responses 0xFF..0xF0 in order on consecutive cycles.
- rsp_ready=0 while issuing 4 reads -> exactly RSP_DEPTH(2) reads accepted, then req_ready=0 for reads while writes are still accepted; raise rsp_ready -> remaining reads flow with no loss or duplication.
- Read 0x20 (old 0x11), then write 0x20 to 0x22 on the next cycle, then read 0x20 -> responses 0x11, then 0x22.
- Assert RST for 1 cycle while a read is pending and the FIFO holds 1 entry -> rsp_valid=0 immediately after the edge; no stale response appears afterwards; the next read of a previously written address returns the correct data.
- Random valid/ready on both sides with RSP_DEPTH=3, 10k requests against a scoreboard model -> all reads match, FIFO count never exceeds 3, CEN never low during RST.
